// File: rtl/common_pkg.sv
// Shared package for the fifo_wr/fifo_rd link blocks: default FIFO depth and the byte type.
package common;
  localparam int FIFO_DEPTH = 16;
  typedef logic [7:0] byte_t;
endpackage

// File: rtl/byte_fifo_mem.sv
// byte_fifo storage: DEPTH x WIDTH array, synchronous write, asynchronous read.
module byte_fifo_mem #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);
  // No reset: contents survive a pointer reset.
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;

  assign rdata = mem[raddr];
endmodule

// File: rtl/byte_fifo.sv
// Single-clock first-word-fall-through byte FIFO with full/empty flow control.
// Define BYTE_FIFO_ERR_EN to add sticky ovf/unf flags and the err_clr input.
module byte_fifo
  import common::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = FIFO_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     wr_en,
  output logic                     full,
  output logic [WIDTH-1:0]         rd_data,
  input  logic                     rd_en,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     active
`ifdef BYTE_FIFO_ERR_EN
  ,
  input  logic                     err_clr,
  output logic                     ovf,
  output logic                     unf
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;
  localparam logic [AW:0] CNT_ONE = 1;

  // Pointers carry one extra wrap bit to tell full from empty.
  logic [AW:0] wp, rp;
  logic        push, pop;

  assign empty  = (wp == rp);
  assign full   = (wp[AW-1:0] == rp[AW-1:0]) && (wp[AW] != rp[AW]);
  assign push   = wr_en && !full;
  assign pop    = rd_en && !empty;
  assign active = (count != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (push) wp <= wp + PTR_ONE;
      if (pop)  rp <= rp + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  byte_fifo_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wp[AW-1:0]),
    .wdata (wr_data),
    .raddr (rp[AW-1:0]),
    .rdata (rd_data)
  );

`ifdef BYTE_FIFO_ERR_EN
  // Set dominates clear so an error in the clearing cycle is not lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf <= 1'b0;
      unf <= 1'b0;
    end else begin
      if (wr_en && full)  ovf <= 1'b1;
      else if (err_clr)   ovf <= 1'b0;
      if (rd_en && empty) unf <= 1'b1;
      else if (err_clr)   unf <= 1'b0;
    end
  end
`endif
endmodule

// File: tb/tb_byte_fifo.sv
// Directed bench for byte_fifo: driver queues expected bytes, a negedge monitor checks pops.
module tb_byte_fifo;
  import common::*;

  logic       clk = 1'b0;
  logic       rst;
  byte_t      wr_data, rd_data;
  logic       wr_en, rd_en, full, empty, active;
  logic [4:0] count;
`ifdef BYTE_FIFO_ERR_EN
  logic       err_clr, ovf, unf;
`endif

  int    errs   = 0;
  int    checks = 0;
  byte_t q[$];

  always #5 clk = ~clk;

  byte_fifo #(.WIDTH(8), .DEPTH(16)) dut (
    .clk     (clk),
    .rst     (rst),
    .wr_data (wr_data),
    .wr_en   (wr_en),
    .full    (full),
    .rd_data (rd_data),
    .rd_en   (rd_en),
    .empty   (empty),
    .count   (count),
    .active  (active)
`ifdef BYTE_FIFO_ERR_EN
    ,
    .err_clr (err_clr),
    .ovf     (ovf),
    .unf     (unf)
`endif
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: every pop the DUT accepts must present the oldest expected byte.
  always @(negedge clk) begin
    if (rst === 1'b0 && rd_en && !empty) begin
      if (q.size() == 0) begin
        checks++;
        errs++;
        $display("FAIL rd_pop: got %02h expected no data", rd_data);
      end else begin
        chk("rd_data", rd_data, q.pop_front());
      end
    end
  end

  // Hold inputs across one rising edge; return 1ns after it. acc says whether the push should land.
  task automatic step(input logic we, input byte_t d, input logic re, input logic acc);
    wr_en   = we;
    wr_data = d;
    rd_en   = re;
    if (we && acc) q.push_back(d);
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; wr_data = '0;
`ifdef BYTE_FIFO_ERR_EN
    err_clr = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_count", count, 0);
    chk("rst_active", active, 0);
    step(0, 8'h00, 0, 0);
    chk("idle_empty", empty, 1);

    // Three pushes then three pops.
    step(1, 8'h11, 0, 1);
    chk("fwft_visible", rd_data, 8'h11);
    step(1, 8'h22, 0, 1);
    step(1, 8'h33, 0, 1);
    chk("cnt3", count, 3);
    chk("cnt3_active", active, 1);
    chk("cnt3_empty", empty, 0);
    repeat (3) step(0, 8'h00, 1, 0);
    chk("drain_empty", empty, 1);
    chk("drain_count", count, 0);

    // Fill, push while full, then push+pop while full.
    for (int i = 0; i < 16; i++) step(1, byte_t'(i), 0, 1);
    chk("fill_full", full, 1);
    chk("fill_count", count, 16);
    step(1, 8'hAA, 0, 0);
    chk("ovr_count", count, 16);
    chk("ovr_full", full, 1);
    step(1, 8'h55, 1, 0);
    chk("fullpp_count", count, 15);
    chk("fullpp_full", full, 0);
    repeat (15) step(0, 8'h00, 1, 0);
    chk("fill_drain_empty", empty, 1);

    // Push and pop while empty: only the push lands.
    step(1, 8'h77, 1, 1);
    chk("emptypp_count", count, 1);
    chk("emptypp_data", rd_data, 8'h77);
    step(0, 8'h00, 1, 0);
    chk("emptypp_drain", count, 0);

    // Sustained push+pop at depth 3 across the pointer wrap.
    for (int i = 0; i < 3; i++) step(1, byte_t'(8'h80 + i), 0, 1);
    for (int i = 0; i < 40; i++) begin
      step(1, byte_t'(8'h83 + i), 1, 1);
      chk("stream_count", count, 3);
    end
    repeat (3) step(0, 8'h00, 1, 0);
    chk("stream_empty", empty, 1);

    // Asynchronous reset with five entries held.
    for (int i = 0; i < 5; i++) step(1, byte_t'(8'hC0 + i), 0, 1);
    chk("pre_rst_count", count, 5);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_count", count, 0);
    chk("async_rst_empty", empty, 1);
    q.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    chk("post_rst_count", count, 0);
    chk("post_rst_active", active, 0);
    step(1, 8'h99, 0, 1);
    chk("post_rst_data", rd_data, 8'h99);
    step(0, 8'h00, 1, 0);

`ifdef BYTE_FIFO_ERR_EN
    chk("unf_clear0", unf, 0);
    step(0, 8'h00, 1, 0);
    chk("unf_set", unf, 1);
    step(0, 8'h00, 0, 0);
    chk("unf_sticky", unf, 1);
    err_clr = 1'b1;
    step(0, 8'h00, 0, 0);
    err_clr = 1'b0;
    chk("unf_cleared", unf, 0);
    chk("ovf_idle", ovf, 0);
`endif

    step(0, 8'h00, 0, 0);
    chk("sb_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/byte_fifo.md
# byte_fifo

Synchronous single-clock byte FIFO that forms the storage end of the `fifo_wr`/`fifo_rd` links. It accepts bytes from a writer engine, which drives data and enable, and presents them in order to a reader engine, which pops with its enable. It sits between a stream producer (e.g. a ctrl-sequenced engine in WRITE) and a consumer (an engine in READ/CHECK). Flow control is by full/empty flags only; nothing is retried.

## Interface
- `WIDTH`, 8, data width in bits.
- `DEPTH`, 16, number of entries; must be a power of two and at least 2.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `wr_data`  in  WIDTH  byte to push.
- `wr_en`  in  1  push request.
- `full`  out  1  no free entry; pushes are ignored.
- `rd_data`  out  WIDTH  head entry (first-word-fall-through).
- `rd_en`  in  1  pop request.
- `empty`  out  1  no valid entry; pops are ignored.
- `count`  out  $clog2(DEPTH)+1  number of valid entries, 0..DEPTH.
- `active`  out  1  high when `count != 0`; matches the ctrl `active` sense.

## Operation
- Storage is a DEPTH x WIDTH array, with write pointer `wp` and read pointer `rp`. Each pointer is $clog2(DEPTH)+1 bits; the MSB is the wrap bit.
- `empty = (wp == rp)`. `full` = address bits equal and wrap bits differ.
- Push is accepted when `wr_en && !full`: `mem[wp] <= wr_data`, `wp` increments.
- Pop is accepted when `rd_en && !empty`: `rp` increments.
- `rd_data = mem[rp]` combinationally. It is valid only while `!empty` and is undefined otherwise.
- `count` is registered: +1 on push only, -1 on pop only, unchanged when both or neither.
- Pointer increment wraps modulo 2*DEPTH; the address field wraps modulo DEPTH.
- Boundary rules:
  - Push while full: ignored, even if a pop is accepted in the same cycle.
  - Pop while empty: ignored, even if a push is accepted in the same cycle.
  - Simultaneous push and pop with 0 < count < DEPTH: both accepted, count unchanged.
  - Reset mid-operation: pointers and count clear; memory contents are not reset.

## Timing
- Reset values:
  - `wp=0`, `rp=0`, `count=0`.
  - `empty=1`, `full=0`, `active=0`.
  - `rd_data` is don't-care.
- Push-to-visible latency: one cycle. A byte pushed at edge N appears on `rd_data` with `empty=0` after edge N.
- A pop at edge N advances `rd_data` to the next entry after edge N.
- `full` and `empty` change only on clock edges, or asynchronously on reset.
- `count`, `full`, `empty` and `active` are mutually consistent in every cycle.
- Throughput: one push and one pop per cycle, sustained.

## Configuration
- `BYTE_FIFO_ERR_EN` defined:
  - Adds output `ovf` (1 bit). It sets sticky when `wr_en && full`.
  - Adds output `unf` (1 bit). It sets sticky when `rd_en && empty`.
  - Adds input `err_clr` (1 bit), which synchronously clears both flags.
  - If `err_clr` and a set condition occur in the same cycle, set wins.
  - Both flags reset to 0.
- Not defined: these ports and registers do not exist. Illegal requests are silently ignored as described above.

## Structure
- Shared package `common` gains:
  - `localparam FIFO_DEPTH = 16`.
  - `typedef logic [7:0] byte_t` for `wr_data`/`rd_data` when `WIDTH=8`.
- One sub-module, `byte_fifo_mem`: the storage array with a synchronous write port and an asynchronous read port. Pointer, flag and count logic stay in `byte_fifo`.

## Test plan
- Reset, then idle: `empty=1`, `full=0`, `count=0`, `active=0`. Assert `rst` mid-stream with count=5: next cycle `count=0`, `empty=1`.
- Push 0x11, 0x22, 0x33 on consecutive cycles, then pop 3: `rd_data` reads 0x11, 0x22, 0x33 in order; `empty=1` after the third pop.
- Push 16 bytes 0x00..0x0F: `full=1`, `count=16`. Push 0xAA while full: ignored. Pop all: sequence 0x00..0x0F, with no 0xAA.
- With count=16, push 0x55 and pop in the same cycle: pop accepted, push rejected, `count=15`.
- With count=0, push 0x77 and pop in the same cycle: push accepted, pop ignored, `count=1`, `rd_data=0x77`.
- Run 40 cycles of simultaneous push/pop with count held at 3, crossing the pointer wrap: data order preserved and count stays 3. With `BYTE_FIFO_ERR_EN`, pop when empty gives `unf=1` until `err_clr`.
